// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - two-requester round-robin arbiter sequencing runs on a shared external counter
//
// Two requesters share one external counter. The arbiter grants the counter to
// one requester and issues a single clear cycle. It then enables counting until
// the counter reaches that requester's latched length. Completion is reported
// with a one-cycle done pulse.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   req[1:0]     in   req[i] high: requester i wants a count run
//   len0, len1   in   requested count length for requester 0 / 1
//   counter_out  in   current value of the shared counter
//   cnt_reset    out  synchronous clear to the shared counter
//   cnt_enable   out  count enable to the shared counter
//   gnt[1:0]     out  one-hot owner of the counter
//   done[1:0]    out  one-cycle completion pulse to the owner
//   busy         out  high in every state except IDLE
module counter_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic [WIDTH-1:0] counter_out,
    output logic             cnt_reset,
    output logic             cnt_enable,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_win;     // index of the current owner
    logic             r_ptr;     // preferred requester on a simultaneous request
    logic [WIDTH-1:0] r_len_q;   // length latched at grant time

    state_t           w_state_nxt;
    logic             w_win_nxt;
    logic             w_ptr_nxt;
    logic [WIDTH-1:0] w_len_nxt;
    logic             w_pick;
    logic             w_owner_req;
    logic             w_at_len;
    logic [1:0]       w_owner_onehot;

    // A lone request wins outright; only a tie consults the pointer.
    always_comb begin
        w_pick = r_ptr;
        if (req == 2'b01) begin
            w_pick = 1'b0;
        end else if (req == 2'b10) begin
            w_pick = 1'b1;
        end
    end

    assign w_owner_req    = req[r_win];
    assign w_at_len       = (counter_out == r_len_q);
    assign w_owner_onehot = {r_win, ~r_win};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_win   <= 1'b0;
            r_ptr   <= 1'b0;
            r_len_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_win   <= w_win_nxt;
            r_ptr   <= w_ptr_nxt;
            r_len_q <= w_len_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win;
        w_ptr_nxt   = r_ptr;
        w_len_nxt   = r_len_q;

        unique case (r_state)
            IDLE: begin
                if (req != 2'b00) begin
                    w_win_nxt   = w_pick;
                    w_len_nxt   = w_pick ? len1 : len0;
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (!w_owner_req) begin
                    w_ptr_nxt   = ~r_win;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // A dropped request takes priority over completion: an
                // abandoned run never reports done.
                if (!w_owner_req) begin
                    w_ptr_nxt   = ~r_win;
                    w_state_nxt = IDLE;
                end else if (w_at_len) begin
                    w_ptr_nxt   = ~r_win;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Everything except cnt_enable is a pure decode of registered state, so
    // reset clears these outputs without waiting for a clock edge.
    assign cnt_reset  = (r_state == CLEAR);
    assign cnt_enable = (r_state == RUN) && !w_at_len;
    assign gnt        = ((r_state == CLEAR) || (r_state == RUN)) ? w_owner_onehot : 2'b00;
    assign done       = (r_state == DONE) ? w_owner_onehot : 2'b00;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - directed self-checking bench for counter_arbiter
module tb_counter_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req   = 2'b00;
    logic [3:0] len0  = 4'd0;
    logic [3:0] len1  = 4'd0;
    logic [3:0] counter_out = 4'd0;
    logic       cnt_reset;
    logic       cnt_enable;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int n_en   = 0;
    int n_clr  = 0;
    int n_done = 0;
    logic saw_gnt11 = 1'b0;

    counter_arbiter #(.WIDTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .len0        (len0),
        .len1        (len1),
        .counter_out (counter_out),
        .cnt_reset   (cnt_reset),
        .cnt_enable  (cnt_enable),
        .gnt         (gnt),
        .done        (done),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    // Model of the shared counter driven by the arbiter.
    always @(posedge clock) begin
        if (cnt_reset) begin
            counter_out <= 4'd0;
        end else if (cnt_enable) begin
            counter_out <= counter_out + 4'd1;
        end
    end

    always @(posedge clock) begin
        if (cnt_enable) n_en <= n_en + 1;
        if (cnt_reset) n_clr <= n_clr + 1;
        if (done != 2'b00) n_done <= n_done + 1;
        if (gnt == 2'b11) saw_gnt11 <= 1'b1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] g, input logic [1:0] d,
                            input logic cr, input logic ce, input logic b);
        chk({tag, "_gnt"}, 32'(gnt), 32'(g));
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_cnt_reset"}, 32'(cnt_reset), 32'(cr));
        chk({tag, "_cnt_enable"}, 32'(cnt_enable), 32'(ce));
        chk({tag, "_busy"}, 32'(busy), 32'(b));
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done != 2'b00) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_done_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_gnt(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (gnt != 2'b00) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_gnt_timeout"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int en0;
        int clr0;
        int done0;
        logic [1:0] exp_g [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};

        // Reset state
        tick();
        tick();
        chk_outs("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk_outs("idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Single requester 0, length 5; len0 changed after grant must not matter
        en0 = n_en; clr0 = n_clr; done0 = n_done;
        req = 2'b01; len0 = 4'd5;
        tick();
        chk_outs("t1_clear", 2'b01, 2'b00, 1'b1, 1'b0, 1'b1);
        len0 = 4'd2;
        tick();
        chk_outs("t1_run0", 2'b01, 2'b00, 1'b0, 1'b1, 1'b1);
        chk("t1_cnt0", 32'(counter_out), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("t1_cnt5", 32'(counter_out), 32'd5);
        chk_outs("t1_run5", 2'b01, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        chk_outs("t1_done", 2'b00, 2'b01, 1'b0, 1'b0, 1'b1);
        req = 2'b00;
        tick();
        chk_outs("t1_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("t1_final_cnt", 32'(counter_out), 32'd5);
        chk("t1_enables", 32'(n_en - en0), 32'd5);
        chk("t1_clears", 32'(n_clr - clr0), 32'd1);
        chk("t1_done_cycles", 32'(n_done - done0), 32'd1);

        // Simultaneous requests from reset: 0 first, then 1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        len0 = 4'd3; len1 = 4'd2; req = 2'b11;
        en0 = n_en;
        tick();
        chk("t2_gnt_first", 32'(gnt), 32'(2'b01));
        wait_done("t2_first");
        chk("t2_done_first", 32'(done), 32'(2'b01));
        chk("t2_en_first", 32'(n_en - en0), 32'd3);
        en0 = n_en;
        tick();
        tick();
        chk("t2_gnt_second", 32'(gnt), 32'(2'b10));
        wait_done("t2_second");
        chk("t2_done_second", 32'(done), 32'(2'b10));
        chk("t2_en_second", 32'(n_en - en0), 32'd2);
        req = 2'b00;
        tick();
        chk("t2_no_gnt11", 32'(saw_gnt11), 32'd0);

        // Zero length on requester 1
        req = 2'b10; len1 = 4'd0;
        en0 = n_en;
        tick();
        chk_outs("t3_clear", 2'b10, 2'b00, 1'b1, 1'b0, 1'b1);
        tick();
        chk_outs("t3_run", 2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        chk_outs("t3_done", 2'b00, 2'b10, 1'b0, 1'b0, 1'b1);
        req = 2'b00;
        tick();
        chk("t3_enables", 32'(n_en - en0), 32'd0);

        // Abort after 4 enables; pointer must then favour requester 1
        req = 2'b01; len0 = 4'd15;
        en0 = n_en; done0 = n_done;
        tick();
        tick();
        for (int i = 0; i < 3; i++) tick();
        req = 2'b00;
        tick();
        chk_outs("t4_abort", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("t4_enables", 32'(n_en - en0), 32'd4);
        chk("t4_cnt", 32'(counter_out), 32'd4);
        tick();
        chk("t4_no_done", 32'(n_done - done0), 32'd0);
        req = 2'b11; len0 = 4'd1; len1 = 4'd1;
        tick();
        chk("t4_ptr_gnt", 32'(gnt), 32'(2'b10));
        wait_done("t4");
        chk("t4_done", 32'(done), 32'(2'b10));
        req = 2'b00;
        tick();

        // Reset in the middle of a run with counter at 7
        req = 2'b01; len0 = 4'd9;
        tick();
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("t5_cnt7", 32'(counter_out), 32'd7);
        chk("t5_en_before", 32'(cnt_enable), 32'd1);
        done0 = n_done;
        reset = 1'b1;
        #1;
        chk_outs("t5_async", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        req = 2'b00;
        tick();
        tick();
        reset = 1'b0;
        chk("t5_no_done", 32'(n_done - done0), 32'd0);
        req = 2'b01; len0 = 4'd2;
        en0 = n_en;
        tick();
        wait_done("t5");
        chk("t5_done", 32'(done), 32'(2'b01));
        chk("t5_enables", 32'(n_en - en0), 32'd2);
        req = 2'b00;
        tick();

        // Continuous simultaneous requests alternate
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 2'b11; len0 = 4'd1; len1 = 4'd1;
        for (int k = 0; k < 4; k++) begin
            wait_gnt("t6");
            chk("t6_gnt", 32'(gnt), 32'(exp_g[k]));
            wait_done("t6");
            chk("t6_done", 32'(done), 32'(exp_g[k]));
            tick();
        end
        req = 2'b00;
        tick();
        chk("t6_no_gnt11", 32'(saw_gnt11), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
